// File: rtl/arc4_pkg.sv
// Shared types and helpers for the ARC4 decryption block: FSM state encoding,
// RAM depth and the key-schedule byte selector.
package arc4_pkg;

    localparam int MEM_DEPTH = 256;

    typedef enum logic [4:0] {
        S_INIT,
        S_KSA_RD_SI,
        S_KSA_WT_SI,
        S_KSA_RD_SJ,
        S_KSA_WT_SJ,
        S_KSA_WR_SI,
        S_KSA_WR_SJ,
        S_PRGA_RD_LEN,
        S_PRGA_WT_LEN,
        S_PRGA_RD_SI,
        S_PRGA_WT_SI,
        S_PRGA_RD_SJ,
        S_PRGA_WT_SJ,
        S_PRGA_WR_SI,
        S_PRGA_WR_SJ,
        S_PRGA_RD_PAD,
        S_PRGA_WT_PAD,
        S_DONE
    } state_t;

    // Byte 0 of the key is the most significant byte of the 24-bit key word.
    function automatic logic [7:0] key_byte(input logic [23:0] k, input logic [7:0] i,
                                            input int nbytes);
        int          b;
        logic [23:0] sh;
        b  = int'(i) % nbytes;
        sh = k >> (8 * (nbytes - 1 - b));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/arc4_task3_top_if.sv
// Single-port RAM access bundle: the FSM is the master, the RAM the slave.
interface arc4_task3_top_if;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wren;
    logic [7:0] rdata;

    modport master (output addr, output wdata, output wren, input rdata);
    modport slave  (input addr, input wdata, input wren, output rdata);
endinterface

// File: rtl/arc4_ram256x8.sv
// 256x8 single-port synchronous RAM with a registered address: read data
// appears the cycle after the address is presented.
module arc4_ram256x8
    import arc4_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH
) (
    input logic              clk_i,
    arc4_task3_top_if.slave  bus
);

    logic [7:0] mem_data [DEPTH];
    logic [7:0] addr_q;

    always_ff @(posedge clk_i) begin
        if (bus.wren) begin
            mem_data[bus.addr] <= bus.wdata;
        end
        addr_q <= bus.addr;
    end

    assign bus.rdata = mem_data[addr_q];

endmodule

// File: rtl/arc4_task3_top.sv
// ARC4 decryptor: S-box init, key schedule, then keystream XOR of the
// length-prefixed ciphertext in ct into pt. LEDR[0]=done, LEDR[1]=busy.
//
// state          | meaning
// INIT           | s[i]=i, one write per cycle
// KSA_RD_SI/WT_SI| fetch s[i], accumulate j
// KSA_RD_SJ/WT_SJ| fetch s[j]
// KSA_WR_SI/WR_SJ| swap writes, advance i
// PRGA_RD/WT_LEN | read ct[0], copy to pt[0]
// PRGA_RD..WR_SJ | i++, j+=s[i], swap (ct[k] fetched alongside s[i])
// PRGA_RD/WT_PAD | fetch s[s[i]+s[j]], write pt[k]
// DONE           | idle until reset
module arc4_task3_top #(
    parameter int KEY_BYTES = 3,
    parameter int MEM_DEPTH = 256
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);
    import arc4_pkg::*;

    logic        rst_n;
    logic [23:0] key_full;
    state_t      state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  k_q, k_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [7:0]  ctb_q, ctb_d;
    logic [7:0]  len_q, len_d;
    logic        unused_ok;

    arc4_task3_top_if s_bus ();
    arc4_task3_top_if ct_bus ();
    arc4_task3_top_if pt_bus ();

    arc4_ram256x8 #(.DEPTH(MEM_DEPTH)) s  (.clk_i(CLOCK_50), .bus(s_bus));
    arc4_ram256x8 #(.DEPTH(MEM_DEPTH)) ct (.clk_i(CLOCK_50), .bus(ct_bus));
    arc4_ram256x8 #(.DEPTH(MEM_DEPTH)) pt (.clk_i(CLOCK_50), .bus(pt_bus));

    assign rst_n     = KEY[3];
    assign key_full  = {14'b0, SW};
    assign unused_ok = ^{KEY[2:0], pt_bus.rdata};

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            ctb_q   <= 8'd0;
            len_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            ctb_q   <= ctb_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        ctb_d   = ctb_q;
        len_d   = len_q;
        case (state_q)
            S_INIT: begin
                i_d = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    j_d     = 8'd0;
                    state_d = S_KSA_RD_SI;
                end
            end
            S_KSA_RD_SI: state_d = S_KSA_WT_SI;
            S_KSA_WT_SI: begin
                si_d    = s_bus.rdata;
                j_d     = j_q + s_bus.rdata + key_byte(key_full, i_q, KEY_BYTES);
                state_d = S_KSA_RD_SJ;
            end
            S_KSA_RD_SJ: state_d = S_KSA_WT_SJ;
            S_KSA_WT_SJ: begin
                sj_d    = s_bus.rdata;
                state_d = S_KSA_WR_SI;
            end
            S_KSA_WR_SI: state_d = S_KSA_WR_SJ;
            S_KSA_WR_SJ: begin
                i_d     = i_q + 8'd1;
                state_d = (i_q == 8'hFF) ? S_PRGA_RD_LEN : S_KSA_RD_SI;
            end
            S_PRGA_RD_LEN: state_d = S_PRGA_WT_LEN;
            S_PRGA_WT_LEN: begin
                len_d   = ct_bus.rdata;
                i_d     = 8'd1;
                j_d     = 8'd0;
                k_d     = 8'd1;
                state_d = (ct_bus.rdata == 8'd0) ? S_DONE : S_PRGA_RD_SI;
            end
            S_PRGA_RD_SI: state_d = S_PRGA_WT_SI;
            S_PRGA_WT_SI: begin
                si_d    = s_bus.rdata;
                ctb_d   = ct_bus.rdata;
                j_d     = j_q + s_bus.rdata;
                state_d = S_PRGA_RD_SJ;
            end
            S_PRGA_RD_SJ: state_d = S_PRGA_WT_SJ;
            S_PRGA_WT_SJ: begin
                sj_d    = s_bus.rdata;
                state_d = S_PRGA_WR_SI;
            end
            S_PRGA_WR_SI:  state_d = S_PRGA_WR_SJ;
            S_PRGA_WR_SJ:  state_d = S_PRGA_RD_PAD;
            S_PRGA_RD_PAD: state_d = S_PRGA_WT_PAD;
            S_PRGA_WT_PAD: begin
                if (k_q == len_q) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 8'd1;
                    i_d     = i_q + 8'd1;
                    state_d = S_PRGA_RD_SI;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        s_bus.addr   = i_q;
        s_bus.wdata  = 8'd0;
        s_bus.wren   = 1'b0;
        ct_bus.addr  = 8'd0;
        ct_bus.wdata = 8'd0;
        ct_bus.wren  = 1'b0;
        pt_bus.addr  = 8'd0;
        pt_bus.wdata = 8'd0;
        pt_bus.wren  = 1'b0;
        case (state_q)
            S_INIT: begin
                s_bus.wdata = i_q;
                s_bus.wren  = 1'b1;
            end
            S_KSA_RD_SJ, S_PRGA_RD_SJ: s_bus.addr = j_q;
            S_KSA_WR_SI, S_PRGA_WR_SI: begin
                s_bus.wdata = sj_q;
                s_bus.wren  = 1'b1;
            end
            S_KSA_WR_SJ, S_PRGA_WR_SJ: begin
                s_bus.addr  = j_q;
                s_bus.wdata = si_q;
                s_bus.wren  = 1'b1;
            end
            S_PRGA_WT_LEN: begin
                pt_bus.wdata = ct_bus.rdata;
                pt_bus.wren  = 1'b1;
            end
            S_PRGA_RD_SI: ct_bus.addr = k_q;
            // si/sj are the pre-swap values; their sum equals the post-swap sum.
            S_PRGA_RD_PAD: s_bus.addr = si_q + sj_q;
            S_PRGA_WT_PAD: begin
                pt_bus.addr  = k_q;
                pt_bus.wdata = s_bus.rdata ^ ctb_q;
                pt_bus.wren  = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            s_bus.wren  = 1'b0;
            pt_bus.wren = 1'b0;
        end
    end

    assign LEDR = rst_n ? {8'd0, (state_q != S_DONE), (state_q == S_DONE)} : 10'd0;
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;

endmodule

// File: tb/tb_arc4_task3_top.sv
// Directed bench for arc4_task3_top: software ARC4 keystream model feeds an
// expected-plaintext queue that is drained against pt once done is seen.
module tb_arc4_task3_top;

    logic       clk = 1'b0;
    logic [3:0] key_in = 4'b0000;
    logic [9:0] sw = 10'd0;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0] ledr;

    always #10 clk = ~clk;

    arc4_task3_top dut (
        .CLOCK_50(clk), .KEY(key_in), .SW(sw),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
        .LEDR(ledr)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] ct_img[256];
    logic [7:0] ks_img[256];
    int         idle_viol = 0;
    int         done_rises = 0;
    logic       done_prev = 1'b0;

    always begin
        @(negedge clk);
        #5;
        idle_viol <= idle_viol
                   + int'({hex0, hex1, hex2, hex3, hex4, hex5} !== {6{7'h7F}} || ledr[9:2] !== 8'h00)
                   + int'(key_in[3] === 1'b0 && ledr !== 10'h000);
        if (ledr[0] === 1'b1 && done_prev === 1'b0) done_rises <= done_rises + 1;
        done_prev <= ledr[0];
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic gen_keystream(input logic [23:0] kk);
        logic [7:0] sb[256];
        logic [7:0] kb[3];
        logic [7:0] i, j, t;
        kb[0] = kk[23:16];
        kb[1] = kk[15:8];
        kb[2] = kk[7:0];
        for (int n = 0; n < 256; n++) sb[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j = j + sb[n] + kb[n % 3];
            t = sb[n]; sb[n] = sb[j]; sb[j] = t;
        end
        i = 8'd0;
        j = 8'd0;
        ks_img[0] = 8'd0;
        for (int n = 1; n < 256; n++) begin
            i = i + 8'd1;
            j = j + sb[i];
            t = sb[i]; sb[i] = sb[j]; sb[j] = t;
            ks_img[n] = sb[8'(sb[i] + sb[j])];
        end
    endtask

    task automatic load_ct();
        for (int n = 0; n < 256; n++) dut.ct.mem_data[n] = ct_img[n];
    endtask

    task automatic fill_pt(input logic [7:0] v);
        for (int n = 0; n < 256; n++) dut.pt.mem_data[n] = v;
    endtask

    task automatic run(input string tag, input logic [9:0] swv, input bit check_init,
                       input bit mid_reset, input bit zero_len);
        int cyc, rises0, drops, len, errs;
        key_in[3] = 1'b0;
        sw = swv;
        repeat (3) @(negedge clk);
        check({tag, "_reset_ledr"}, int'(ledr), 0);
        rises0 = done_rises;
        key_in[3] = 1'b1;
        cyc = 0;
        if (check_init) begin
            repeat (258) @(negedge clk);
            cyc = 258;
            errs = 0;
            for (int n = 0; n < 256; n++) if (dut.s.mem_data[n] !== 8'(n)) errs++;
            check("init_identity_errs", errs, 0);
            check("init_busy", int'(ledr[1:0]), 2);
        end
        if (mid_reset) begin
            repeat (578) @(negedge clk);
            key_in[3] = 1'b0;
            @(negedge clk);
            check("midrst_ledr", int'(ledr), 0);
            key_in[3] = 1'b1;
            cyc = 0;
        end
        while (ledr[0] !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, int'(ledr[0]), 1);
        if (zero_len) check("zero_done_latency", int'(cyc > 1792 && cyc <= 1796), 1);
        drops = 0;
        repeat (20) begin
            @(negedge clk);
            if (ledr[1:0] !== 2'b01) drops++;
        end
        check({tag, "_done_stable"}, drops, 0);
        check({tag, "_done_rises"}, done_rises - rises0, 1);
        len = int'(ct_img[0]);
        check({tag, "_sb_size"}, exp_q.size(), len + 1);
        for (int n = 0; n <= len; n++) begin
            if (exp_q.size() > 0)
                check($sformatf("%s_pt[%0d]", tag, n), int'(dut.pt.mem_data[n]),
                      int'(exp_q.pop_front()));
        end
    endtask

    initial begin
        string msg;
        int    errs;
        msg = "Hello ARC4 world";

        repeat (4) @(negedge clk);
        check("por_reset_ledr", int'(ledr), 0);

        gen_keystream(24'h000018);
        for (int n = 0; n < 256; n++) ct_img[n] = 8'($urandom_range(0, 255));
        ct_img[0] = 8'(msg.len());
        exp_q.push_back(8'(msg.len()));
        for (int n = 1; n <= msg.len(); n++) begin
            ct_img[n] = msg[n-1] ^ ks_img[n];
            exp_q.push_back(msg[n-1]);
        end
        load_ct();
        fill_pt(8'h00);
        run("full", 10'h018, 1'b1, 1'b0, 1'b0);

        exp_q.push_back(8'(msg.len()));
        for (int n = 1; n <= msg.len(); n++) exp_q.push_back(msg[n-1]);
        fill_pt(8'h00);
        run("midrst", 10'h018, 1'b0, 1'b1, 1'b0);

        ct_img[0] = 8'd0;
        load_ct();
        fill_pt(8'h5A);
        exp_q.push_back(8'd0);
        run("zero", 10'h018, 1'b0, 1'b0, 1'b1);
        errs = 0;
        for (int n = 1; n < 256; n++) if (dut.pt.mem_data[n] !== 8'h5A) errs++;
        check("zero_untouched_errs", errs, 0);

        gen_keystream(24'h0003FF);
        ct_img[0] = 8'd255;
        exp_q.push_back(8'd255);
        for (int n = 1; n < 256; n++) begin
            ct_img[n] = 8'($urandom_range(0, 255));
            exp_q.push_back(ct_img[n] ^ ks_img[n]);
        end
        load_ct();
        fill_pt(8'h00);
        run("max", 10'h3FF, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        check("idle_outputs_viol", idle_viol, 0);
        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
